// File: rtl/sync_fifo_fwft.sv
`timescale 1ns/1ps
// sync_fifo_fwft: single-clock FIFO with binary pointers, occupancy counter,
// optional first-word-fall-through read port, programmable almost flags and
// sticky overflow/underflow indicators.
module sync_fifo_fwft #(
  parameter int DATA_WIDTH      = 80,
  parameter int ADDRESS_WIDTH   = 7,
  parameter int FIFO_DEPTH      = (1 << ADDRESS_WIDTH),
  parameter int FWFT_MODE       = 0,
  parameter int ALMOST_FULL_TH  = FIFO_DEPTH - 4,
  parameter int ALMOST_EMPTY_TH = 4
) (
  input  logic                   Clk,
  input  logic                   Rst_n_in,
  input  logic                   Clear_in,
  input  logic [DATA_WIDTH-1:0]  Data_in,
  input  logic                   WriteEn_in,
  output logic                   Full_out,
  output logic                   AlmostFull_out,
  output logic [DATA_WIDTH-1:0]  Data_out,
  input  logic                   ReadEn_in,
  output logic                   Empty_out,
  output logic                   AlmostEmpty_out,
  output logic [ADDRESS_WIDTH:0] Count_out,
  output logic                   Overflow_out,
  output logic                   Underflow_out
);

  localparam int CW = ADDRESS_WIDTH + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(ALMOST_FULL_TH);
  localparam logic [CW-1:0] AE_C    = CW'(ALMOST_EMPTY_TH);
  localparam logic [ADDRESS_WIDTH-1:0] PTR_ONE = ADDRESS_WIDTH'(1);

  logic [DATA_WIDTH-1:0]    mem [FIFO_DEPTH];
  logic [ADDRESS_WIDTH-1:0] wr_ptr;
  logic [ADDRESS_WIDTH-1:0] rd_ptr;
  logic [CW-1:0]            count_q;
  logic [CW-1:0]            count_nxt;
  logic [CW-1:0]            mem_cnt;
  // Head register holds a valid word (only ever set in FWFT mode)
  logic                     head_vld;
  logic                     head_vld_nxt;
  logic                     wr_acc;
  logic                     rd_acc;
  // Pop from memory into the Data_out register this cycle
  logic                     mem_rd;

  // Accept decisions, memory pop and next occupancy from the registered flags
  always_comb begin
    wr_acc       = WriteEn_in & ~Full_out;
    rd_acc       = ReadEn_in & ~Empty_out;
    mem_cnt      = count_q - CW'(head_vld);
    mem_rd       = rd_acc;
    head_vld_nxt = 1'b0;
    if (FWFT_MODE != 0) begin
      // Refill the head whenever it is free or being acknowledged. A pop and a
      // write never hit the same slot: that would need a full memory, which
      // the occupied head register rules out.
      mem_rd       = (mem_cnt != '0) & (~head_vld | rd_acc);
      head_vld_nxt = mem_rd | (head_vld & ~rd_acc);
    end
    count_nxt = count_q + CW'(wr_acc) - CW'(rd_acc);
  end

  // Storage write port; contents need no reset
  always_ff @(posedge Clk) begin
    if (Rst_n_in && !Clear_in && wr_acc)
      mem[wr_ptr] <= Data_in;
  end

  // Pointers, counter, read data and all registered flags
  always_ff @(posedge Clk) begin
    if (!Rst_n_in || Clear_in) begin
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      count_q         <= '0;
      head_vld        <= 1'b0;
      Data_out        <= '0;
      Full_out        <= 1'b0;
      Empty_out       <= 1'b1;
      AlmostFull_out  <= 1'b0;
      AlmostEmpty_out <= 1'b1;
      Overflow_out    <= 1'b0;
      Underflow_out   <= 1'b0;
    end else begin
      if (wr_acc)
        wr_ptr <= wr_ptr + PTR_ONE;
      if (mem_rd) begin
        rd_ptr   <= rd_ptr + PTR_ONE;
        Data_out <= mem[rd_ptr];
      end
      count_q         <= count_nxt;
      head_vld        <= head_vld_nxt;
      Full_out        <= (count_nxt == DEPTH_C);
      AlmostFull_out  <= (count_nxt >= AF_C);
      AlmostEmpty_out <= (count_nxt <= AE_C);
      Empty_out       <= (FWFT_MODE != 0) ? ~head_vld_nxt : (count_nxt == '0);
      Overflow_out    <= Overflow_out | (WriteEn_in & Full_out);
      Underflow_out   <= Underflow_out | (ReadEn_in & Empty_out);
    end
  end

  assign Count_out = count_q;

endmodule

// File: tb/tb_sync_fifo_fwft.sv
`timescale 1ns/1ps
// Bench for sync_fifo_fwft: a standard-mode instance checked through a
// reference queue and cycle-tagged scoreboard, plus an FWFT-mode instance
// checked with directed expectations.
module tb_sync_fifo_fwft;

  localparam int DW = 80;
  localparam int AW = 7;
  localparam int DEPTH = 128;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Standard-mode instance
  logic          rst_n0 = 1'b0, clr0 = 1'b0, we0 = 1'b0, re0 = 1'b0;
  logic [DW-1:0] din0 = '0;
  logic          full0, af0, empty0, ae0, ovf0, unf0;
  logic [DW-1:0] dout0;
  logic [AW:0]   cnt0;

  // FWFT-mode instance
  logic          rst_n1 = 1'b0, clr1 = 1'b0, we1 = 1'b0, re1 = 1'b0;
  logic [DW-1:0] din1 = '0;
  logic          full1, af1, empty1, ae1, ovf1, unf1;
  logic [DW-1:0] dout1;
  logic [AW:0]   cnt1;

  sync_fifo_fwft #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .FWFT_MODE(0)) dut0 (
    .Clk(clk), .Rst_n_in(rst_n0), .Clear_in(clr0), .Data_in(din0),
    .WriteEn_in(we0), .Full_out(full0), .AlmostFull_out(af0),
    .Data_out(dout0), .ReadEn_in(re0), .Empty_out(empty0),
    .AlmostEmpty_out(ae0), .Count_out(cnt0), .Overflow_out(ovf0),
    .Underflow_out(unf0));

  sync_fifo_fwft #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .FWFT_MODE(1)) dut1 (
    .Clk(clk), .Rst_n_in(rst_n1), .Clear_in(clr1), .Data_in(din1),
    .WriteEn_in(we1), .Full_out(full1), .AlmostFull_out(af1),
    .Data_out(dout1), .ReadEn_in(re1), .Empty_out(empty1),
    .AlmostEmpty_out(ae1), .Count_out(cnt1), .Overflow_out(ovf1),
    .Underflow_out(unf1));

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  typedef struct {
    int            cyc;
    logic [DW-1:0] d;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;

  // Reference model of the standard-mode instance
  logic [DW-1:0] mq[$];
  int            mcnt = 0;
  bit            movf = 1'b0, munf = 1'b0;
  logic [DW-1:0] mdata = '0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Scoreboard monitor: read data is due one edge after an accepted read
  always @(posedge clk) begin
    cyc++;
    #1;
    if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
      mon_e = exp_q.pop_front();
      chk("rd_data", dout0, mon_e.d);
    end
  end

  task automatic flags0();
    chk("count",  80'(cnt0),   80'(mcnt));
    chk("full",   80'(full0),  80'(mcnt == DEPTH));
    chk("empty",  80'(empty0), 80'(mcnt == 0));
    chk("afull",  80'(af0),    80'(mcnt >= DEPTH - 4));
    chk("aempty", 80'(ae0),    80'(mcnt <= 4));
    chk("ovf",    80'(ovf0),   80'(movf));
    chk("unf",    80'(unf0),   80'(munf));
  endtask

  task automatic step0(input bit rstn, input bit clr, input bit we,
                       input logic [DW-1:0] d, input bit re, input bit do_chk);
    bit wacc, racc;
    @(negedge clk);
    rst_n0 = rstn; clr0 = clr; we0 = we; din0 = d; re0 = re;
    if (!rstn || clr) begin
      mq.delete(); mcnt = 0; movf = 1'b0; munf = 1'b0; mdata = '0;
    end else begin
      wacc = we && (mcnt < DEPTH);
      racc = re && (mcnt > 0);
      if (we && mcnt == DEPTH) movf = 1'b1;
      if (re && mcnt == 0) munf = 1'b1;
      if (racc) begin
        mdata = mq.pop_front();
        exp_q.push_back('{cyc + 1, mdata});
      end
      if (wacc) mq.push_back(d);
      mcnt += int'(wacc) - int'(racc);
    end
    @(posedge clk);
    #1;
    if (do_chk) flags0();
  endtask

  task automatic step1(input bit rstn, input bit we, input logic [DW-1:0] d, input bit re);
    @(negedge clk);
    rst_n1 = rstn; clr1 = 1'b0; we1 = we; din1 = d; re1 = re;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] d;

    // Reset
    step0(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    step0(1'b0, 1'b0, 1'b1, 80'h77, 1'b1, 1'b1);
    chk("reset_dout", dout0, '0);

    // Fill 0x01..0x80, then one write too many
    for (int i = 1; i <= DEPTH + 1; i++)
      step0(1'b1, 1'b0, 1'b1, 80'(i), 1'b0, 1'b1);

    // Drain all, then one read too many; data must hold the last word
    for (int i = 1; i <= DEPTH + 1; i++)
      step0(1'b1, 1'b0, 1'b0, '0, 1'b1, 1'b1);
    chk("hold_dout", dout0, 80'h80);

    // Steady simultaneous read/write at 64 words across pointer wrap
    step0(1'b1, 1'b1, 1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 64; i++) begin
      d = {16'h3000, 64'(i)};
      step0(1'b1, 1'b0, 1'b1, d, 1'b0, 1'b0);
    end
    for (int i = 0; i < 300; i++) begin
      d = {16'h3333, 64'(i)};
      step0(1'b1, 1'b0, 1'b1, d, 1'b1, 1'b1);
    end

    // Clear together with a write: word discarded, flags cleared
    step0(1'b1, 1'b1, 1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++)
      step0(1'b1, 1'b0, 1'b1, 80'(16'h5000 + i), 1'b0, 1'b0);
    step0(1'b1, 1'b1, 1'b1, 80'hDEAD, 1'b1, 1'b1);
    chk("clear_dout", dout0, '0);
    step0(1'b1, 1'b0, 1'b1, 80'h55, 1'b0, 1'b1);
    step0(1'b1, 1'b0, 1'b0, '0, 1'b1, 1'b1);

    // Reset in the middle of a write burst
    for (int i = 0; i < 5; i++)
      step0(1'b1, 1'b0, 1'b1, 80'(16'h6000 + i), 1'b0, 1'b0);
    step0(1'b0, 1'b0, 1'b1, 80'hBEEF, 1'b1, 1'b1);
    chk("rst_dout", dout0, '0);

    // Full with read+write: read wins, write rejected
    for (int i = 0; i < DEPTH; i++)
      step0(1'b1, 1'b0, 1'b1, 80'(16'h7000 + i), 1'b0, 1'b0);
    step0(1'b1, 1'b0, 1'b1, 80'hFFFF, 1'b1, 1'b1);
    // Empty with read+write: write wins, read rejected
    step0(1'b1, 1'b1, 1'b0, '0, 1'b0, 1'b1);
    step0(1'b1, 1'b0, 1'b1, 80'h99, 1'b1, 1'b1);
    step0(1'b1, 1'b0, 1'b0, '0, 1'b1, 1'b1);
    step0(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b1);

    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end

    // FWFT instance
    step1(1'b0, 1'b0, '0, 1'b0);
    step1(1'b0, 1'b0, '0, 1'b0);
    chk("f_rst_empty", 80'(empty1), 80'(1));
    chk("f_rst_cnt",   80'(cnt1),   80'(0));
    chk("f_rst_dout",  dout1,       '0);
    step1(1'b1, 1'b1, 80'hAA, 1'b0);
    chk("f_wr_cnt",    80'(cnt1),   80'(1));
    chk("f_wr_empty",  80'(empty1), 80'(1));
    step1(1'b1, 1'b0, '0, 1'b0);
    chk("f_head_empty", 80'(empty1), 80'(0));
    chk("f_head_dout",  dout1,       80'hAA);
    step1(1'b1, 1'b1, 80'hBB, 1'b0);
    chk("f_wr2_cnt",   80'(cnt1),   80'(2));
    chk("f_wr2_dout",  dout1,       80'hAA);
    step1(1'b1, 1'b0, '0, 1'b1);
    chk("f_pop_dout",  dout1,       80'hBB);
    chk("f_pop_cnt",   80'(cnt1),   80'(1));
    chk("f_pop_empty", 80'(empty1), 80'(0));
    step1(1'b1, 1'b0, '0, 1'b1);
    chk("f_last_cnt",   80'(cnt1),   80'(0));
    chk("f_last_empty", 80'(empty1), 80'(1));
    chk("f_last_ae",    80'(ae1),    80'(1));
    chk("f_last_unf",   80'(unf1),   80'(0));
    step1(1'b1, 1'b0, '0, 1'b1);
    chk("f_unf", 80'(unf1), 80'(1));

    // FWFT fill to capacity, overflow, then drain checking order
    step1(1'b0, 1'b0, '0, 1'b0);
    for (int i = 0; i < DEPTH; i++)
      step1(1'b1, 1'b1, {16'hF0F0, 64'(i)}, 1'b0);
    chk("f_full",     80'(full1), 80'(1));
    chk("f_full_cnt", 80'(cnt1),  80'(DEPTH));
    chk("f_full_af",  80'(af1),   80'(1));
    step1(1'b1, 1'b1, 80'h1234, 1'b0);
    chk("f_ovf",      80'(ovf1),  80'(1));
    chk("f_ovf_cnt",  80'(cnt1),  80'(DEPTH));
    for (int i = 0; i < DEPTH; i++) begin
      chk("f_drain_empty", 80'(empty1), 80'(0));
      chk("f_drain_dout",  dout1,       {16'hF0F0, 64'(i)});
      step1(1'b1, 1'b0, '0, 1'b1);
    end
    chk("f_drained_empty", 80'(empty1), 80'(1));
    chk("f_drained_cnt",   80'(cnt1),   80'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
